// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: code-groups, GMII codes and
// one-hot state encodings for the receive and transmit machines.
package pcs_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] K_V   = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  localparam logic [7:0] GMII_FALSE_CARRIER = 8'h0E;
  localparam logic [7:0] GMII_PREAMBLE      = 8'h55;

  localparam int RX_LF_B = 0;
  localparam int RX_WK_B = 1;
  localparam int RX_RK_B = 2;
  localparam int RX_ID_B = 3;
  localparam int RX_RC_B = 4;
  localparam int RX_TR_B = 5;

  localparam logic [5:0] RX_LINK_FAILED = 6'b000001;
  localparam logic [5:0] RX_WAIT_FOR_K  = 6'b000010;
  localparam logic [5:0] RX_RX_K        = 6'b000100;
  localparam logic [5:0] RX_IDLE_D      = 6'b001000;
  localparam logic [5:0] RX_RECEIVE     = 6'b010000;
  localparam logic [5:0] RX_TRI_RRI     = 6'b100000;

  localparam logic [4:0] TX_IDLE      = 5'b00001;
  localparam logic [4:0] TX_START     = 5'b00010;
  localparam logic [4:0] TX_DATA      = 5'b00100;
  localparam logic [4:0] TX_END_T     = 5'b01000;
  localparam logic [4:0] TX_END_R     = 5'b10000;

endpackage

// File: rtl/pcs_rx_classify.sv
// Combinational code-group classifier; exactly one flag is set
// for any input.
module pcs_rx_classify
  import pcs_pkg::*;
(
  input  logic [7:0] rx_code_group,
  input  logic       rx_is_k,
  output logic       is_comma,
  output logic       is_s,
  output logic       is_t,
  output logic       is_r,
  output logic       is_v,
  output logic       is_idle_d,
  output logic       is_data,
  output logic       is_other_k
);

  logic idle_val;

  assign idle_val   = (rx_code_group == D5_6) ||
                      (rx_code_group == D16_2);
  assign is_comma   = rx_is_k && (rx_code_group == K28_5);
  assign is_s       = rx_is_k && (rx_code_group == K_S);
  assign is_t       = rx_is_k && (rx_code_group == K_T);
  assign is_r       = rx_is_k && (rx_code_group == K_R);
  assign is_v       = rx_is_k && (rx_code_group == K_V);
  assign is_idle_d  = !rx_is_k && idle_val;
  assign is_data    = !rx_is_k && !idle_val;
  assign is_other_k = rx_is_k && !is_comma && !is_s &&
                      !is_t && !is_r && !is_v;

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive machine: code-groups in, registered
// GMII RXD/RX_DV/RX_ER out, with saturating status counters.
module pcs_receive
  import pcs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             sync_status,
  input  logic [7:0]       rx_code_group,
  input  logic             rx_is_k,
  output logic [7:0]       RXD,
  output logic             RX_DV,
  output logic             RX_ER,
  output logic             receiving,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic       is_comma, is_s, is_t, is_r;
  logic       is_v, is_idle_d, is_data, is_other_k;
  logic [5:0] state, state_n;
  logic [7:0] rxd_n;
  logic       dv_n, er_n, rcv_n, pkt_inc;

  pcs_rx_classify u_classify (
    .rx_code_group (rx_code_group),
    .rx_is_k       (rx_is_k),
    .is_comma      (is_comma),
    .is_s          (is_s),
    .is_t          (is_t),
    .is_r          (is_r),
    .is_v          (is_v),
    .is_idle_d     (is_idle_d),
    .is_data       (is_data),
    .is_other_k    (is_other_k)
  );

  always_comb begin
    state_n = state;
    rxd_n   = 8'h00;
    dv_n    = 1'b0;
    er_n    = 1'b0;
    rcv_n   = 1'b0;
    pkt_inc = 1'b0;
    if (!sync_status) begin
      // Losing alignment mid-frame marks the frame as aborted
      state_n = RX_LINK_FAILED;
      dv_n    = RX_DV;
      er_n    = RX_DV;
    end else begin
      unique case (1'b1)
        state[RX_LF_B]: state_n = RX_WAIT_FOR_K;
        state[RX_WK_B]: begin
          if (is_comma) state_n = RX_RX_K;
        end
        state[RX_RK_B]: begin
          state_n = is_idle_d ? RX_IDLE_D : RX_WAIT_FOR_K;
        end
        state[RX_ID_B]: begin
          if (is_comma) begin
            state_n = RX_RX_K;
          end else if (is_s) begin
            state_n = RX_RECEIVE;
            rxd_n   = GMII_PREAMBLE;
            dv_n    = 1'b1;
            rcv_n   = 1'b1;
          end else begin
            state_n = RX_WAIT_FOR_K;
            rxd_n   = GMII_FALSE_CARRIER;
            er_n    = 1'b1;
          end
        end
        state[RX_RC_B]: begin
          if (is_data || is_idle_d) begin
            rxd_n = rx_code_group;
            dv_n  = 1'b1;
            rcv_n = 1'b1;
          end else if (is_t) begin
            state_n = RX_TRI_RRI;
          end else if (is_comma) begin
            state_n = RX_RX_K;
            dv_n    = 1'b1;
            er_n    = 1'b1;
          end else begin
            rxd_n = rx_code_group;
            dv_n  = 1'b1;
            er_n  = 1'b1;
            rcv_n = 1'b1;
          end
        end
        state[RX_TR_B]: begin
          state_n = RX_WAIT_FOR_K;
          pkt_inc = is_r;
          er_n    = !is_r;
        end
        default: state_n = RX_LINK_FAILED;
      endcase
    end
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state     <= RX_LINK_FAILED;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      RXD       <= rxd_n;
      RX_DV     <= dv_n;
      RX_ER     <= er_n;
      receiving <= rcv_n;
      if (pkt_inc && (pkt_count != '1))
        pkt_count <= pkt_count + ONE;
      if (er_n && (err_count != '1))
        err_count <= err_count + ONE;
    end
  end

endmodule
